// File: rtl/imt_pmod_gpio_apb_if.sv
// APB bus bundle for the pmod GPIO controller.
//   master: drives PADDR/PSEL/PENABLE/PWRITE/PWDATA, samples PRDATA/PREADY/PSLVERR
//   slave : the reverse
interface imt_pmod_gpio_apb_if;
  logic [31:0] PADDR;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  modport master (output PADDR, PSEL, PENABLE, PWRITE, PWDATA,
                  input  PRDATA, PREADY, PSLVERR);
  modport slave  (input  PADDR, PSEL, PENABLE, PWRITE, PWDATA,
                  output PRDATA, PREADY, PSLVERR);
endinterface

// File: rtl/imt_pmod_gpio_apb.sv
// APB-attached GPIO controller for the subsystem pmod pins.
//   imt_pmod_gpio_pin : per-pin synchroniser, optional debounce filter and
//                       enabled rise/fall edge detect.
//   imt_pmod_gpio_apb : top. Ports:
//     clk_in, reset_int (async, active low)
//     apb            : APB slave (zero wait state, registered PRDATA)
//     irq_en_1       : interrupt enable, irq_1 = registered irq_en_1 & |STATUS
//     ss_ctrl_1[0]   : safe mode, forces pmod_gpio_oe low
//     pmod_gpi       : raw asynchronous pin inputs
//     pmod_gpo       : OUT register
//     pmod_gpio_oe   : OE register gated by safe mode
// Map: 0x00 OUT, 0x04 OE, 0x08 IN (RO), 0x0C RISE_EN, 0x10 FALL_EN,
//      0x14 STATUS (W1C), 0x18 DEBOUNCE (only with GPIO_DEBOUNCE_EN).
// Define GPIO_DEBOUNCE_EN to add the per-pin debounce counters.

module imt_pmod_gpio_pin #(
  parameter int SYNC_STAGES = 2,
  parameter int DB_W        = 8
) (
  input  logic            clk_in,
  input  logic            reset_int,
  input  logic            gpi,
  input  logic            rise_en,
  input  logic            fall_en,
`ifdef GPIO_DEBOUNCE_EN
  input  logic [DB_W-1:0] db_lim,
`endif
  output logic            filt,
  output logic            edge_hit
);
  logic [SYNC_STAGES-1:0] sync;
  logic                   filt_q;

  always_ff @(posedge clk_in or negedge reset_int)
    if (!reset_int) sync <= '0;
    else            sync <= {sync[SYNC_STAGES-2:0], gpi};

`ifdef GPIO_DEBOUNCE_EN
  // For a single bit, "differs from filt" already implies the synchronised
  // value is unchanged from last cycle, so one compare resets the count.
  logic [DB_W-1:0] cnt;
  always_ff @(posedge clk_in or negedge reset_int)
    if (!reset_int) begin
      cnt  <= '0;
      filt <= 1'b0;
    end else if (sync[SYNC_STAGES-1] == filt) begin
      cnt  <= '0;
    end else if (cnt == db_lim) begin
      cnt  <= '0;
      filt <= sync[SYNC_STAGES-1];
    end else begin
      cnt  <= cnt + 1'b1;
    end
`else
  localparam int unused_db_w = DB_W;
  assign filt = sync[SYNC_STAGES-1];
`endif

  always_ff @(posedge clk_in or negedge reset_int)
    if (!reset_int) filt_q <= 1'b0;
    else            filt_q <= filt;

  assign edge_hit = (filt & ~filt_q & rise_en) | (~filt & filt_q & fall_en);
endmodule

module imt_pmod_gpio_apb #(
  parameter int NPINS       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int DB_W        = 8
) (
  input  logic                 clk_in,
  input  logic                 reset_int,
  imt_pmod_gpio_apb_if.slave   apb,
  input  logic                 irq_en_1,
  input  logic [7:0]           ss_ctrl_1,
  output logic                 irq_1,
  input  logic [NPINS-1:0]     pmod_gpi,
  output logic [NPINS-1:0]     pmod_gpo,
  output logic [NPINS-1:0]     pmod_gpio_oe
);
`ifdef GPIO_DEBOUNCE_EN
  localparam logic [5:0] MAX_IDX = 6'd6;
`else
  localparam logic [5:0] MAX_IDX = 6'd5;
`endif

  logic [NPINS-1:0] out_r, oe_r, rise_en_r, fall_en_r, status_r;
  logic [NPINS-1:0] filt, hit, clr, wdata;
  logic [31:0]      prdata_r, rd_val;
  logic [5:0]       idx;
  logic             setup, access, mapped, wr_en, rd_setup;
`ifdef GPIO_DEBOUNCE_EN
  logic [DB_W-1:0]  db_r;
`endif

  assign idx      = apb.PADDR[7:2];
  assign setup    = apb.PSEL & ~apb.PENABLE;
  assign access   = apb.PSEL &  apb.PENABLE;
  assign mapped   = (apb.PADDR[1:0] == 2'b00) && (idx <= MAX_IDX);
  assign wr_en    = access & apb.PWRITE & mapped;
  assign rd_setup = setup & ~apb.PWRITE;
  assign wdata    = apb.PWDATA[NPINS-1:0];
  assign clr      = (wr_en && idx == 6'd5) ? wdata : '0;

  // Bus outputs are gated by reset so they read 0 while reset is held.
  assign apb.PREADY  = reset_int & access;
  assign apb.PSLVERR = reset_int & access & ~mapped;
  assign apb.PRDATA  = prdata_r;

  assign pmod_gpo     = out_r;
  assign pmod_gpio_oe = oe_r & ~{NPINS{ss_ctrl_1[0]}};

  logic unused_bits;
  assign unused_bits = ^{ss_ctrl_1[7:1], apb.PADDR[31:8], apb.PWDATA};

  for (genvar g = 0; g < NPINS; g++) begin : g_pin
    imt_pmod_gpio_pin #(.SYNC_STAGES(SYNC_STAGES), .DB_W(DB_W)) u_pin (
      .clk_in   (clk_in),
      .reset_int(reset_int),
      .gpi      (pmod_gpi[g]),
      .rise_en  (rise_en_r[g]),
      .fall_en  (fall_en_r[g]),
`ifdef GPIO_DEBOUNCE_EN
      .db_lim   (db_r),
`endif
      .filt     (filt[g]),
      .edge_hit (hit[g])
    );
  end

  always_comb begin
    rd_val = '0;
    if (mapped)
      case (idx)
        6'd0: rd_val[NPINS-1:0] = out_r;
        6'd1: rd_val[NPINS-1:0] = oe_r;
        6'd2: rd_val[NPINS-1:0] = filt;
        6'd3: rd_val[NPINS-1:0] = rise_en_r;
        6'd4: rd_val[NPINS-1:0] = fall_en_r;
        6'd5: rd_val[NPINS-1:0] = status_r;
`ifdef GPIO_DEBOUNCE_EN
        6'd6: rd_val[DB_W-1:0]  = db_r;
`endif
        default: rd_val = '0;
      endcase
  end

  always_ff @(posedge clk_in or negedge reset_int)
    if (!reset_int) begin
      out_r     <= '0;
      oe_r      <= '0;
      rise_en_r <= '0;
      fall_en_r <= '0;
      status_r  <= '0;
      prdata_r  <= '0;
      irq_1     <= 1'b0;
`ifdef GPIO_DEBOUNCE_EN
      db_r      <= '0;
`endif
    end else begin
      if (wr_en)
        case (idx)
          6'd0: out_r     <= wdata;
          6'd1: oe_r      <= wdata;
          6'd3: rise_en_r <= wdata;
          6'd4: fall_en_r <= wdata;
`ifdef GPIO_DEBOUNCE_EN
          6'd6: db_r      <= apb.PWDATA[DB_W-1:0];
`endif
          default: ;
        endcase
      // A new edge in the same cycle as a W1C keeps the bit set.
      status_r <= (status_r & ~clr) | hit;
      irq_1    <= irq_en_1 & (|status_r);
      if (rd_setup) prdata_r <= rd_val;
    end
endmodule

// File: tb/tb_imt_pmod_gpio_apb.sv
module tb_imt_pmod_gpio_apb;
  localparam int NPINS = 16;

  logic             clk_in = 1'b0;
  logic             reset_int = 1'b0;
  logic             irq_en_1;
  logic [7:0]       ss_ctrl_1;
  logic             irq_1;
  logic [NPINS-1:0] pmod_gpi, pmod_gpo, pmod_gpio_oe;

  imt_pmod_gpio_apb_if apb();

  imt_pmod_gpio_apb #(.NPINS(NPINS), .SYNC_STAGES(2), .DB_W(8)) dut (
    .clk_in      (clk_in),
    .reset_int   (reset_int),
    .apb         (apb),
    .irq_en_1    (irq_en_1),
    .ss_ctrl_1   (ss_ctrl_1),
    .irq_1       (irq_1),
    .pmod_gpi    (pmod_gpi),
    .pmod_gpo    (pmod_gpo),
    .pmod_gpio_oe(pmod_gpio_oe)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [NPINS-1:0] m_out, m_oe, m_re, m_fe, m_st, m_pins;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic apb_wr(input logic [31:0] a, input logic [31:0] d, output logic err);
    @(posedge clk_in) #1;
    apb.PSEL = 1'b1; apb.PENABLE = 1'b0; apb.PWRITE = 1'b1; apb.PADDR = a; apb.PWDATA = d;
    @(posedge clk_in) #1;
    apb.PENABLE = 1'b1;
    #1;
    chk("wr_pready", {31'd0, apb.PREADY}, 32'd1);
    err = apb.PSLVERR;
    @(posedge clk_in) #1;
    apb.PSEL = 1'b0; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0;
  endtask

  task automatic apb_rd(input logic [31:0] a, output logic [31:0] d, output logic err);
    @(posedge clk_in) #1;
    apb.PSEL = 1'b1; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0; apb.PADDR = a;
    @(posedge clk_in) #1;
    apb.PENABLE = 1'b1;
    #1;
    d   = apb.PRDATA;
    err = apb.PSLVERR;
    @(posedge clk_in) #1;
    apb.PSEL = 1'b0; apb.PENABLE = 1'b0;
  endtask

  function automatic logic [NPINS-1:0] model_reg(input int i);
    case (i)
      0: return m_out;
      1: return m_oe;
      2: return m_pins;
      3: return m_re;
      4: return m_fe;
      default: return m_st;
    endcase
  endfunction

  initial begin
    logic [31:0] rd;
    logic        err;
    logic [NPINS-1:0] np, cd;
    int op, ri;

    apb.PSEL = 1'b0; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0;
    apb.PADDR = '0; apb.PWDATA = '0;
    irq_en_1 = 1'b0; ss_ctrl_1 = 8'h00; pmod_gpi = '0;

    // outputs held quiet during reset, even with an erroring access on the bus
    repeat (3) @(posedge clk_in);
    #1;
    apb.PSEL = 1'b1; apb.PENABLE = 1'b1; apb.PADDR = 32'h1C;
    #1;
    chk("rst_pready",  {31'd0, apb.PREADY},  32'd0);
    chk("rst_pslverr", {31'd0, apb.PSLVERR}, 32'd0);
    chk("rst_prdata",  apb.PRDATA, 32'd0);
    chk("rst_irq",     {31'd0, irq_1}, 32'd0);
    chk("rst_gpo",     {16'd0, pmod_gpo}, 32'd0);
    chk("rst_oe",      {16'd0, pmod_gpio_oe}, 32'd0);
    apb.PSEL = 1'b0; apb.PENABLE = 1'b0;

    // reset asserted in the access phase of an OUT write aborts it
    @(posedge clk_in) #1 reset_int = 1'b1;
    @(posedge clk_in) #1;
    apb.PSEL = 1'b1; apb.PWRITE = 1'b1; apb.PADDR = 32'h00; apb.PWDATA = 32'hFFFF;
    @(posedge clk_in) #1;
    apb.PENABLE = 1'b1;
    #2 reset_int = 1'b0;
    @(posedge clk_in) #1;
    apb.PSEL = 1'b0; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0;
    chk("abort_gpo", {16'd0, pmod_gpo}, 32'd0);
    #3 reset_int = 1'b1;
    for (int i = 0; i < 6; i++) begin
      apb_rd(32'(i * 4), rd, err);
      chk($sformatf("rst_reg%0d", i), rd, 32'd0);
    end
    chk("rst_gpo2", {16'd0, pmod_gpo}, 32'd0);
    chk("rst_oe2",  {16'd0, pmod_gpio_oe}, 32'd0);
    chk("rst_irq2", {31'd0, irq_1}, 32'd0);

    // output path and safe mode
    apb_wr(32'h00, 32'hA5A5, err);
    chk("wr_out_err", {31'd0, err}, 32'd0);
    apb_wr(32'h04, 32'h00FF, err);
    chk("gpo",  {16'd0, pmod_gpo}, 32'hA5A5);
    chk("oe",   {16'd0, pmod_gpio_oe}, 32'h00FF);
    ss_ctrl_1 = 8'h01;
    #1;
    chk("oe_safe", {16'd0, pmod_gpio_oe}, 32'd0);
    apb_rd(32'h04, rd, err);
    chk("oe_reg_safe", rd, 32'h00FF);
    ss_ctrl_1 = 8'h00;
    #1;
    chk("oe_unsafe", {16'd0, pmod_gpio_oe}, 32'h00FF);

    // rising edge on pin 0: STATUS after 3 edges, irq_1 after 4
    apb_wr(32'h0C, 32'h0001, err);
    irq_en_1 = 1'b1;
    @(posedge clk_in) #1 pmod_gpi[0] = 1'b1;
    @(posedge clk_in);
    @(posedge clk_in);
    @(posedge clk_in) #1;
    chk("irq_early", {31'd0, irq_1}, 32'd0);
    @(posedge clk_in) #1;
    chk("irq_set", {31'd0, irq_1}, 32'd1);
    apb_rd(32'h08, rd, err);
    chk("in_bit0", rd, 32'h0001);
    apb_rd(32'h14, rd, err);
    chk("status_rise", rd, 32'h0001);
    apb_wr(32'h14, 32'h0001, err);
    chk("irq_hold", {31'd0, irq_1}, 32'd1);
    @(posedge clk_in) #1;
    chk("irq_clr", {31'd0, irq_1}, 32'd0);

    // falling edge on pin 3 coincident with its W1C: set wins
    apb_wr(32'h10, 32'h0008, err);
    pmod_gpi[3] = 1'b1;
    repeat (6) @(posedge clk_in);
    apb_rd(32'h14, rd, err);
    chk("status_norise3", rd, 32'h0000);
    @(posedge clk_in) #1 pmod_gpi[3] = 1'b0;
    apb_wr(32'h14, 32'h0008, err);
    apb_rd(32'h14, rd, err);
    chk("status_setwins", rd, 32'h0008);
    apb_wr(32'h14, 32'h0008, err);
    apb_rd(32'h14, rd, err);
    chk("status_clr3", rd, 32'h0000);

    // error responses
    apb_rd(32'h00, rd, err);
    chk("out_pre_err", rd, 32'hA5A5);
    apb_rd(32'h1C, rd, err);
    chk("rd1c_err",  {31'd0, err}, 32'd1);
    chk("rd1c_data", rd, 32'd0);
    apb_rd(32'h18, rd, err);
`ifdef GPIO_DEBOUNCE_EN
    chk("rd18_err", {31'd0, err}, 32'd0);
`else
    chk("rd18_err", {31'd0, err}, 32'd1);
`endif
    apb_wr(32'h02, 32'hFFFF, err);
    chk("wr02_err", {31'd0, err}, 32'd1);
    apb_rd(32'h00, rd, err);
    chk("out_after_err", rd, 32'hA5A5);
    apb_wr(32'h08, 32'hFFFF, err);
    chk("wr_in_err", {31'd0, err}, 32'd0);
    apb_rd(32'h08, rd, err);
    chk("in_ro", rd, 32'h0001);

`ifdef GPIO_DEBOUNCE_EN
    apb_wr(32'h18, 32'd4, err);
    apb_wr(32'h0C, 32'h0002, err);
    @(posedge clk_in) #1 pmod_gpi[1] = 1'b1;
    repeat (3) @(posedge clk_in);
    #1 pmod_gpi[1] = 1'b0;
    repeat (10) @(posedge clk_in);
    apb_rd(32'h08, rd, err);
    chk("db_short_in", rd & 32'h2, 32'h0);
    apb_rd(32'h14, rd, err);
    chk("db_short_st", rd, 32'h0);
    @(posedge clk_in) #1 pmod_gpi[1] = 1'b1;
    repeat (12) @(posedge clk_in);
    apb_rd(32'h08, rd, err);
    chk("db_long_in", rd & 32'h2, 32'h2);
`endif

    // randomized phase against the register-level model
    apb_wr(32'h0C, 32'h0, err);
    apb_wr(32'h10, 32'h0, err);
    apb_wr(32'h14, 32'hFFFF, err);
    m_out = 16'hA5A5; m_oe = 16'h00FF; m_re = '0; m_fe = '0; m_st = '0;
    m_pins = pmod_gpi;
    for (int n = 0; n < 60; n++) begin
      op = int'($urandom_range(0, 3));
      case (op)
        0: begin
          ri = int'($urandom_range(0, 3));
          np = 16'($urandom);
          case (ri)
            0: begin apb_wr(32'h00, {16'd0, np}, err); m_out = np; end
            1: begin apb_wr(32'h04, {16'd0, np}, err); m_oe = np; end
            2: begin apb_wr(32'h0C, {16'd0, np}, err); m_re = np; end
            default: begin apb_wr(32'h10, {16'd0, np}, err); m_fe = np; end
          endcase
          ss_ctrl_1 = {7'($urandom), 1'($urandom)};
          #1;
          chk("rnd_gpo", {16'd0, pmod_gpo}, {16'd0, m_out});
          chk("rnd_oe", {16'd0, pmod_gpio_oe}, {16'd0, ss_ctrl_1[0] ? 16'd0 : m_oe});
        end
        1: begin
          np = 16'($urandom);
          m_st = m_st | (np & ~m_pins & m_re) | (~np & m_pins & m_fe);
          m_pins = np;
          @(posedge clk_in) #1 pmod_gpi = np;
          repeat (14) @(posedge clk_in);
          #1;
          chk("rnd_irq_edge", {31'd0, irq_1}, {31'd0, irq_en_1 & (|m_st)});
        end
        2: begin
          cd = 16'($urandom);
          apb_wr(32'h14, {16'd0, cd}, err);
          m_st = m_st & ~cd;
          repeat (2) @(posedge clk_in);
          #1;
          chk("rnd_irq_clr", {31'd0, irq_1}, {31'd0, irq_en_1 & (|m_st)});
        end
        default: begin
          irq_en_1 = 1'($urandom);
          repeat (2) @(posedge clk_in);
          #1;
          chk("rnd_irq_en", {31'd0, irq_1}, {31'd0, irq_en_1 & (|m_st)});
        end
      endcase
      ri = int'($urandom_range(0, 5));
      apb_rd(32'(ri * 4), rd, err);
      chk($sformatf("rnd_rd%0d", ri), rd, {16'd0, model_reg(ri)});
      chk("rnd_rd_err", {31'd0, err}, 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // hard stop in case the stimulus stalls
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/imt_pmod_gpio_apb.md
Name: imt_pmod_gpio_apb

Overview:
Parametrised APB-attached GPIO controller for the subsystem pmod pins, successor to the fixed 16-bit pass-through pmod wiring. It provides registered output/OE control, synchronised input sampling, per-pin rising/falling edge detection with sticky status, and a level interrupt gated by the subsystem `irq_en_1` control. It instantiates inside the subsystem integration layer beside the functional core and drives `pmod_gpo` and `pmod_gpio_oe`.

Parameters:
- NPINS, 16, number of GPIO pins (1..32); register bits above NPINS-1 read 0 and ignore writes.
- SYNC_STAGES, 2, input synchroniser depth (>=2).
- DB_W, 8, debounce counter width (used only with the optional feature).

Ports:
- clk_in  in  1  system clock; all logic on rising edge.
- reset_int  in  1  asynchronous active-low reset.
- PADDR  in  32  APB address; PADDR[7:0] decoded, word aligned.
- PENABLE  in  1  APB enable.
- PSEL  in  1  APB select.
- PWDATA  in  32  APB write data.
- PWRITE  in  1  APB write strobe.
- PRDATA  out  32  APB read data.
- PREADY  out  1  APB ready.
- PSLVERR  out  1  APB error.
- irq_en_1  in  1  subsystem interrupt enable.
- ss_ctrl_1  in  8  subsystem control; bit0 = safe mode; bits 7:1 unused.
- irq_1  out  1  level interrupt.
- pmod_gpi  in  NPINS  raw pin inputs (asynchronous).
- pmod_gpo  out  NPINS  pin output values.
- pmod_gpio_oe  out  NPINS  pin output enables (1 = drive).

Behaviour:
- Reset (reset_int=0) clears all registers, synchronisers, filters and status.
  - Outputs during reset: PRDATA=0, PREADY=0, PSLVERR=0, irq_1=0, pmod_gpo=0, pmod_gpio_oe=0.
  - Reset asserted mid-transfer aborts the transfer; no register is updated.
- APB handshake:
  - Zero wait states. PREADY=1 exactly when PSEL&PENABLE, else 0.
  - Writes commit on the clk_in edge ending the access phase (PSEL&PENABLE&PWRITE).
  - PRDATA is registered: captured in the setup phase (PSEL&!PENABLE&!PWRITE) and held until the next read; 0 after reset.
  - PSLVERR=1 in the access phase for an unmapped or misaligned (PADDR[1:0]!=0) address. Such writes are discarded; such reads return 0.
- Register map:
  - 0x00 OUT (RW)
  - 0x04 OE (RW)
  - 0x08 IN (RO): filtered input; writes are ignored without error.
  - 0x0C RISE_EN (RW)
  - 0x10 FALL_EN (RW)
  - 0x14 STATUS (RW1C)
  - 0x18 DEBOUNCE (RW, optional feature only)
- Outputs:
  - pmod_gpo = OUT, registered.
  - pmod_gpio_oe = OE & {NPINS{~ss_ctrl_1[0]}}. Safe mode forces all OE low combinationally from the register; OE register contents are kept.
- Input path:
  - pmod_gpi passes through a SYNC_STAGES flop chain, then the filter, to produce filt.
  - IN reflects a pin change SYNC_STAGES cycles after it (debounce off).
- Edge detection:
  - filt_q = filt delayed by one cycle.
  - rise = filt & ~filt_q & RISE_EN; fall = ~filt & filt_q & FALL_EN.
  - STATUS[i] sets on rise[i] | fall[i].
  - Clear by writing 1 in the same cycle as a new edge: set wins, bit stays 1.
- Interrupt:
  - irq_1 is registered: irq_1 <= irq_en_1 & |STATUS.
  - Assertion occurs one cycle after the STATUS bit sets.
  - Deasserts one cycle after STATUS reaches 0 or irq_en_1 drops.
  - Clearing irq_en_1 does not clear STATUS.

Optional Feature:
Macro GPIO_DEBOUNCE_EN.
- Defined:
  - DEBOUNCE register at 0x18: DB_W bits, reset 0.
  - Each pin has a DB_W-bit counter. filt[i] updates only after the synchronised value has differed from filt[i] for DEBOUNCE+1 consecutive cycles.
  - The counter resets whenever the synchronised value equals filt[i] or differs from its previous-cycle value.
  - DEBOUNCE=0 gives one cycle of added latency.
- Undefined:
  - filt = synchroniser output, with no counters.
  - 0x18 is unmapped: PSLVERR=1, read 0.

Test Plan:
- Reset values: with reset_int=0 mid-write of OUT=0xFFFF, release and read 0x00..0x14 -> all 0, pmod_gpo=0, pmod_gpio_oe=0, irq_1=0.
- Output path: write OUT=0xA5A5, OE=0x00FF -> pmod_gpo=0xA5A5, pmod_gpio_oe=0x00FF. Set ss_ctrl_1=0x01 -> pmod_gpio_oe=0; read OE -> 0x00FF.
- Input and rising edge: RISE_EN=0x0001, irq_en_1=1, drive pmod_gpi[0] 0->1 -> IN bit0=1 after 2 cycles, STATUS=0x0001 next cycle, irq_1=1 one cycle later. Write STATUS=0x0001 -> irq_1=0.
- Simultaneous set/clear: falling edge on pin 3 with FALL_EN=0x0008 in the same cycle as a STATUS=0x0008 write -> STATUS stays 0x0008.
- Errors: read 0x1C -> PSLVERR=1, PRDATA=0. Write 0x02 -> PSLVERR=1, no register changes.
- Debounce (GPIO_DEBOUNCE_EN): DEBOUNCE=4, pulse pin 1 high for 3 cycles -> IN unchanged, no STATUS. Hold high for 5 cycles -> IN bit1=1.
